avoid_motor_ctrl: RTL and testbench

Motion controller directly downstream of the ultrasonic ranging stage. Consumes its registered path-clear flag and the latched remote drive command, and runs an autonomous brake/reverse/turn avoidance sequence when a forward move meets an obstacle. Drives the L298N-style H-bridge: four direction pins and two PWM enables. Sits between the command decoder (remote link) and the car's motor pins, all in the 50 MHz `clk` domain.

---
 rtl/avoid_motor_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_avoid_motor_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/avoid_motor_ctrl.sv
// Obstacle-avoiding motion controller: remote command latch, debounced path-clear flag,
// brake/reverse/turn sequencer and L298N-style direction/PWM drive.
module avoid_motor_ctrl #(
  parameter int unsigned PWM_PERIOD = 1000,
  parameter int unsigned DUTY_FWD   = 700,
  parameter int unsigned DUTY_TURN  = 500,
  parameter int unsigned FILT_CYC   = 1000,
  parameter int unsigned BRAKE_CYC  = 5000000,
  parameter int unsigned REV_CYC    = 20000000,
  parameter int unsigned TURN_CYC   = 25000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic [2:0] cmd,
  input  logic       cmd_valid,
  output logic       in1,
  output logic       in2,
  output logic       in3,
  output logic       in4,
  output logic       ena,
  output logic       enb,
  output logic       avoid_busy,
  output logic [1:0] state_o
);

  localparam int unsigned PWM_W   = $clog2(PWM_PERIOD + 1);
  localparam int unsigned FILT_W  = $clog2(FILT_CYC + 1);
  localparam int unsigned DWELL_W = 25;

  localparam logic [2:0] CMD_STOP  = 3'd0;
  localparam logic [2:0] CMD_FWD   = 3'd1;
  localparam logic [2:0] CMD_BACK  = 3'd2;
  localparam logic [2:0] CMD_LEFT  = 3'd3;
  localparam logic [2:0] CMD_RIGHT = 3'd4;

  typedef enum logic [1:0] {
    S_DRIVE   = 2'd0,
    S_BRAKE   = 2'd1,
    S_REVERSE = 2'd2,
    S_TURN    = 2'd3
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic [2:0]           cmd_reg;
  logic [2:0]           cmd_dec_c;
  logic                 abort_c;
  logic                 obs;
  logic [FILT_W-1:0]    filt_cnt;
  logic [DWELL_W-1:0]   dwell_cnt;
  logic                 turn_dir;
  logic                 dir_flip_c;
  logic [PWM_W-1:0]     pwm_cnt;
  logic [PWM_W-1:0]     duty_act;
  logic [PWM_W-1:0]     duty_req_c;
  logic [3:0]           pins_c;
  logic                 en_c;

  // Unused command codes behave as stop; a stop strobe aborts avoidance.
  assign cmd_dec_c = (cmd > CMD_RIGHT) ? CMD_STOP : cmd;
  assign abort_c   = cmd_valid && (cmd_dec_c == CMD_STOP);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cmd_reg <= CMD_STOP;
    end else if (cmd_valid) begin
      cmd_reg <= cmd_dec_c;
    end
  end

  // Obstacle flag flips only after the raw level has disagreed for FILT_CYC cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      obs      <= 1'b0;
      filt_cnt <= '0;
    end else if (clear == obs) begin
      if (filt_cnt == FILT_W'(FILT_CYC - 1)) begin
        obs      <= ~obs;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end else begin
      filt_cnt <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_DRIVE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, direction pins and requested duty for the current state.
  always_comb begin
    state_d    = state_q;
    dir_flip_c = 1'b0;
    pins_c     = 4'b0000;
    duty_req_c = '0;
    case (state_q)
      S_DRIVE: begin
        case (cmd_reg)
          CMD_FWD:   begin pins_c = 4'b1010; duty_req_c = PWM_W'(DUTY_FWD);  end
          CMD_BACK:  begin pins_c = 4'b0101; duty_req_c = PWM_W'(DUTY_FWD);  end
          CMD_LEFT:  begin pins_c = 4'b0110; duty_req_c = PWM_W'(DUTY_TURN); end
          CMD_RIGHT: begin pins_c = 4'b1001; duty_req_c = PWM_W'(DUTY_TURN); end
          default:   begin pins_c = 4'b0000; duty_req_c = '0;                end
        endcase
        if ((cmd_reg == CMD_FWD) && obs) begin
          state_d = S_BRAKE;
        end
      end
      S_BRAKE: begin
        pins_c = 4'b1111;
        if (abort_c) begin
          state_d = S_DRIVE;
        end else if (dwell_cnt == DWELL_W'(BRAKE_CYC - 1)) begin
          state_d = S_REVERSE;
        end
      end
      S_REVERSE: begin
        pins_c     = 4'b0101;
        duty_req_c = PWM_W'(DUTY_TURN);
        if (abort_c) begin
          state_d = S_DRIVE;
        end else if (dwell_cnt == DWELL_W'(REV_CYC - 1)) begin
          state_d = S_TURN;
        end
      end
      S_TURN: begin
        pins_c     = turn_dir ? 4'b0110 : 4'b1001;
        duty_req_c = PWM_W'(DUTY_TURN);
        if (abort_c) begin
          state_d = S_DRIVE;
        end else if (dwell_cnt == DWELL_W'(TURN_CYC - 1)) begin
          state_d    = S_DRIVE;
          dir_flip_c = 1'b1;
        end
      end
      default: state_d = S_DRIVE;
    endcase
    en_c = (state_q == S_BRAKE) || ((duty_req_c != '0) && (pwm_cnt < duty_act));
  end

  // Dwell timer restarts on every state entry and idles at zero in DRIVE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dwell_cnt <= '0;
    end else if ((state_d != state_q) || (state_q == S_DRIVE)) begin
      dwell_cnt <= '0;
    end else begin
      dwell_cnt <= dwell_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      turn_dir <= 1'b0;
    end else if (dir_flip_c) begin
      turn_dir <= ~turn_dir;
    end
  end

  // Duty only changes at the period wrap so no runt pulses reach the bridge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pwm_cnt  <= '0;
      duty_act <= '0;
    end else if (pwm_cnt == PWM_W'(PWM_PERIOD - 1)) begin
      pwm_cnt  <= '0;
      duty_act <= duty_req_c;
    end else begin
      pwm_cnt  <= pwm_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      {in1, in2, in3, in4} <= 4'b0000;
      ena                  <= 1'b0;
      enb                  <= 1'b0;
      avoid_busy           <= 1'b0;
      state_o              <= 2'd0;
    end else begin
      {in1, in2, in3, in4} <= pins_c;
      ena                  <= en_c;
      enb                  <= en_c;
      avoid_busy           <= (state_q != S_DRIVE);
      state_o              <= state_q;
    end
  end

endmodule

// File: tb/tb_avoid_motor_ctrl.sv
// Randomized and directed bench for avoid_motor_ctrl against a cycle-level behavioural model.
module tb_avoid_motor_ctrl;

  localparam int unsigned P  = 10;
  localparam int unsigned DF = 7;
  localparam int unsigned DT = 5;
  localparam int unsigned F  = 8;
  localparam int unsigned BC = 10;
  localparam int unsigned RC = 20;
  localparam int unsigned TC = 30;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b1;
  logic [2:0] cmd = 3'd0;
  logic       cmd_valid = 1'b0;
  logic       in1, in2, in3, in4, ena, enb, avoid_busy;
  logic [1:0] state_o;
  logic [3:0] pins;

  int n_checks = 0;
  int n_fail   = 0;

  assign pins = {in1, in2, in3, in4};

  always #5 clk = ~clk;

  avoid_motor_ctrl #(
    .PWM_PERIOD(P), .DUTY_FWD(DF), .DUTY_TURN(DT), .FILT_CYC(F),
    .BRAKE_CYC(BC), .REV_CYC(RC), .TURN_CYC(TC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .cmd(cmd), .cmd_valid(cmd_valid),
    .in1(in1), .in2(in2), .in3(in3), .in4(in4), .ena(ena), .enb(enb),
    .avoid_busy(avoid_busy), .state_o(state_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural reference: mode 0 drive, 1 brake, 2 reverse, 3 turn.
  int m_cmd = 0, m_obs = 0, m_run = 0, m_mode = 0, m_el = 0, m_dir = 0, m_phase = 0, m_duty = 0;
  int e_state = 0, e_pins = 0, e_en = 0, e_busy = 0;

  function automatic int dec(input int c);
    return (c > 4) ? 0 : c;
  endfunction

  function automatic int req(input int mode, input int c);
    if (mode == 0) return (c == 1 || c == 2) ? DF : ((c == 3 || c == 4) ? DT : 0);
    if (mode == 1) return 0;
    return DT;
  endfunction

  function automatic int pins_of(input int mode, input int c, input int dir);
    if (mode == 1) return 4'b1111;
    if (mode == 2) return 4'b0101;
    if (mode == 3) return (dir != 0) ? 4'b0110 : 4'b1001;
    case (c)
      1: return 4'b1010;
      2: return 4'b0101;
      3: return 4'b0110;
      4: return 4'b1001;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic int dur(input int mode);
    return (mode == 1) ? BC : ((mode == 2) ? RC : TC);
  endfunction

  always @(posedge clk) begin
    int nm, nd;
    if (!rst_n) begin
      m_cmd = 0; m_obs = 0; m_run = 0; m_mode = 0; m_el = 0; m_dir = 0; m_phase = 0; m_duty = 0;
      e_state = 0; e_pins = 0; e_en = 0; e_busy = 0;
    end else begin
      e_state = m_mode;
      e_pins  = pins_of(m_mode, m_cmd, m_dir);
      e_busy  = (m_mode != 0) ? 1 : 0;
      e_en    = (m_mode == 1 || (req(m_mode, m_cmd) != 0 && m_phase < m_duty)) ? 1 : 0;
      nm = m_mode;
      nd = m_dir;
      if (m_mode != 0 && cmd_valid && dec(int'(cmd)) == 0) nm = 0;
      else if (m_mode == 0) begin
        if (m_cmd == 1 && m_obs == 1) nm = 1;
      end else if (m_el == dur(m_mode) - 1) begin
        nm = (m_mode == 3) ? 0 : m_mode + 1;
        if (m_mode == 3) nd = 1 - m_dir;
      end
      m_el = (nm != m_mode) ? 0 : m_el + 1;
      if (m_phase == P - 1) begin
        m_phase = 0;
        m_duty  = req(m_mode, m_cmd);
      end else m_phase++;
      if (cmd_valid) m_cmd = dec(int'(cmd));
      if ((clear ? 1 : 0) == m_obs) begin
        if (m_run == F - 1) begin m_obs = 1 - m_obs; m_run = 0; end
        else m_run++;
      end else m_run = 0;
      m_mode = nm;
      m_dir  = nd;
    end
    #1;
    check("state", 32'(state_o), 32'(e_state));
    check("pins", 32'(pins), 32'(e_pins));
    check("ena", 32'(ena), 32'(e_en));
    check("enb", 32'(enb), 32'(e_en));
    check("busy", 32'(avoid_busy), 32'(e_busy));
  end

  task automatic strobe(input logic [2:0] c);
    cmd = c;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic run_len(input logic [1:0] v, output int n);
    n = 0;
    while (state_o == v && n < 1000) begin n++; @(negedge clk); end
  endtask

  task automatic wait_state(input logic [1:0] v, input string tag);
    int k = 0;
    while (state_o != v && k < 1000) begin k++; @(negedge clk); end
    check(tag, 32'(state_o), 32'(v));
  endtask

  initial begin
    int n, k, hi, lo, hold;
    repeat (3) @(negedge clk);
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_pins", 32'(pins), 32'd0);
    check("rst_en", 32'({ena, enb, avoid_busy}), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Forward: pins two edges after the strobe, then 7/3 PWM.
    strobe(3'd1);
    @(negedge clk);
    check("fwd_pins", 32'(pins), 32'b1010);
    k = 0; while (ena !== 1'b0 && k < 100) begin k++; @(negedge clk); end
    k = 0; while (ena !== 1'b1 && k < 100) begin k++; @(negedge clk); end
    hi = 0; while (ena === 1'b1 && hi < 100) begin hi++; @(negedge clk); end
    lo = 0; while (ena === 1'b0 && lo < 100) begin lo++; @(negedge clk); end
    check("ena_high", 32'(hi), 32'(DF));
    check("ena_low", 32'(lo), 32'(P - DF));

    // Filter: F-1 cycles of obstacle is ignored, F cycles trips the brake.
    clear = 1'b0;
    repeat (F - 1) @(negedge clk);
    clear = 1'b1;
    repeat (2 * F) @(negedge clk);
    check("glitch_state", 32'(state_o), 32'd0);
    clear = 1'b0;
    repeat (F + 1) @(negedge clk);
    check("obs_lat_early", 32'(state_o), 32'd0);
    @(negedge clk);
    check("brake_state", 32'(state_o), 32'd1);
    check("brake_pins", 32'(pins), 32'b1111);
    check("brake_en", 32'({ena, enb, avoid_busy}), 32'b111);

    // Full episode, then a re-triggered one turning the other way.
    run_len(2'd1, n); check("brake_len", 32'(n), 32'(BC));
    check("rev_pins", 32'(pins), 32'b0101);
    run_len(2'd2, n); check("rev_len", 32'(n), 32'(RC));
    check("turn1_pins", 32'(pins), 32'b1001);
    run_len(2'd3, n); check("turn_len", 32'(n), 32'(TC));
    run_len(2'd0, n); check("retrig_drive_len", 32'(n), 32'd1);
    run_len(2'd1, n); check("brake2_len", 32'(n), 32'(BC));
    run_len(2'd2, n); check("rev2_len", 32'(n), 32'(RC));
    check("turn2_pins", 32'(pins), 32'b0110);
    run_len(2'd3, n); check("turn2_len", 32'(n), 32'(TC));
    run_len(2'd0, n); check("retrig2_drive_len", 32'(n), 32'd1);

    // Abort in REVERSE, then abort in TURN must not flip the turn direction.
    wait_state(2'd2, "ep3_rev_wait");
    strobe(3'd0);
    @(negedge clk);
    check("abort_state", 32'(state_o), 32'd0);
    check("abort_pins", 32'(pins), 32'd0);
    check("abort_en", 32'({ena, enb, avoid_busy}), 32'd0);
    strobe(3'd1);
    wait_state(2'd3, "ep4_turn_wait");
    check("ep4_dir", 32'(pins), 32'b1001);
    strobe(3'd0);
    @(negedge clk);
    check("abort_turn_state", 32'(state_o), 32'd0);
    strobe(3'd1);
    wait_state(2'd3, "ep5_turn_wait");
    check("ep5_dir_kept", 32'(pins), 32'b1001);
    strobe(3'd0);
    repeat (2) @(negedge clk);

    // Backward is never blocked by an obstacle.
    strobe(3'd2);
    @(negedge clk);
    check("back_pins", 32'(pins), 32'b0101);
    repeat (3 * F) @(negedge clk);
    check("back_unblocked", 32'({state_o, avoid_busy}), 32'd0);

    // Code 6 behaves as stop.
    clear = 1'b1;
    repeat (2 * F) @(negedge clk);
    strobe(3'd1);
    @(negedge clk);
    check("fwd2_pins", 32'(pins), 32'b1010);
    strobe(3'd6);
    @(negedge clk);
    check("cmd6_pins", 32'(pins), 32'd0);
    check("cmd6_en", 32'({ena, enb}), 32'd0);

    // Synchronous reset in TURN clears every output on that edge.
    clear = 1'b0;
    strobe(3'd1);
    wait_state(2'd3, "rst_turn_wait");
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_state", 32'(state_o), 32'd0);
    check("midrst_pins", 32'(pins), 32'd0);
    check("midrst_en", 32'({ena, enb, avoid_busy}), 32'd0);
    rst_n = 1'b1;
    clear = 1'b1;
    @(negedge clk);

    // Random traffic, checked every cycle by the model.
    hold = 0;
    repeat (4000) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      if ($urandom_range(0, 29) == 0) begin
        cmd = ($urandom_range(0, 1) == 0) ? 3'd1 : 3'($urandom_range(0, 7));
        cmd_valid = 1'b1;
      end
      if (hold == 0) begin
        clear = ~clear;
        hold = $urandom_range(1, 4 * F);
      end else hold--;
      rst_n = ($urandom_range(0, 1999) != 0);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
